// File: rtl/mat_operand_loader.sv
// mat_operand_loader: collects a 24-element frame (4x4 matrix A, then 4x2
// matrix B) from a valid/ready element stream. It then presents both matrices
// in flat form to the downstream multiplier until that stage consumes them.
// Optional build macro: MAT_LOAD_LAST_CHECK_EN enables in_last framing checks
// and the sticky err flag. Without it, in_last is ignored and err stays 0.
module mat_operand_loader #(
    parameter int DW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic            in_last,
    output logic [16*DW-1:0] a_flat,
    output logic [8*DW-1:0]  b_flat,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] FULL = 2'd2;

    localparam logic [4:0] LAST_IDX = 5'd23;

    logic [1:0]        state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [16*DW-1:0]  a_q, a_d;
    logic [8*DW-1:0]   b_q, b_d;
    logic              err_q, err_d;
    logic              accept;
    logic              mismatch;

    // Handshake outputs decode from state only, so in_valid/out_ready never reach them combinationally
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q == FULL);
    assign accept    = in_valid && in_ready;

`ifdef MAT_LOAD_LAST_CHECK_EN
    // Framing error: in_last must be high exactly on the final slot
    assign mismatch = (idx_q == LAST_IDX) ? !in_last : in_last;
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign mismatch       = 1'b0;
`endif

    // Next-state, slot write and error computation
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;
        if (flush) begin
            // Matrix contents are deliberately kept; only the frame position is discarded
            state_d = IDLE;
            idx_d   = 5'd0;
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    if (accept) begin
                        if (mismatch) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                            idx_d   = 5'd0;
                        end else begin
                            if (idx_q[4]) begin
                                b_d[DW*int'(idx_q[2:0]) +: DW] = in_data;
                            end else begin
                                a_d[DW*int'(idx_q[3:0]) +: DW] = in_data;
                            end
                            if (idx_q == LAST_IDX) begin
                                state_d = FULL;
                                idx_d   = 5'd0;
                            end else begin
                                state_d = LOAD;
                                idx_d   = idx_q + 5'd1;
                            end
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = 5'd0;
                end
            endcase
        end
    end

    // State, index, matrix storage and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 5'd0;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
        end
    end

    assign a_flat = a_q;
    assign b_flat = b_q;
    assign err    = err_q;

endmodule

// File: tb/tb_mat_operand_loader.sv
// Directed testbench for mat_operand_loader (DW=4).
module tb_mat_operand_loader;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        in_last;
    logic [63:0] a_flat;
    logic [31:0] b_flat;
    logic        out_valid;
    logic        out_ready;
    logic        err;

    int total = 0;
    int bad   = 0;

    // Frame 0: reference matrices. Frame 1: A_k = 15-k, B_k = k+1.
    logic [3:0] frame0 [24] = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd1, 4'd2, 4'd3,
                                4'd3, 4'd1, 4'd1, 4'd2, 4'd4, 4'd2, 4'd1, 4'd1,
                                4'd6, 4'd5, 4'd1, 4'd3, 4'd3, 4'd2, 4'd7, 4'd3};
    logic [3:0] frame1 [24] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8,
                                4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0,
                                4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};

    localparam logic [63:0] A0_EXP   = 64'h1124_2113_3212_2221;
    localparam logic [31:0] B0_EXP   = 32'h3723_3156;
    localparam logic [63:0] A1_EXP   = 64'h0123_4567_89AB_CDEF;
    localparam logic [31:0] B1_EXP   = 32'h8765_4321;
    localparam logic [63:0] AFL_EXP  = 64'h1124_2167_89AB_CDEF;

    mat_operand_loader #(.DW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one element and hold it until accepted (bounded wait)
    task automatic push(input logic [3:0] d, input logic last);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int t = 0; t < 50 && !done; t++) begin
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) chk("push_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_range(input int sel, input bit gapped, input int lo, input int hi,
                              input int last_at);
        logic [3:0] d;
        for (int i = lo; i <= hi; i++) begin
            if (gapped) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            if (i == 23) chk("ov_before_last", {63'd0, out_valid}, 64'd0);
            d = (sel == 0) ? frame0[i] : frame1[i];
            push(d, i == last_at);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    int s0;

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_a_flat", a_flat, 64'd0);
        chk("rst_b_flat", {32'd0, b_flat}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame: out_valid one cycle after the 24th accept
        send_range(0, 1'b0, 0, 23, 23);
        chk("basic_out_valid", {63'd0, out_valid}, 64'd1);
        chk("basic_in_ready", {63'd0, in_ready}, 64'd0);
        chk("basic_a_flat", a_flat, A0_EXP);
        chk("basic_b_flat", {32'd0, b_flat}, {32'd0, B0_EXP});
        s0 = 0;
        for (int k = 0; k < 4; k++) s0 += int'(a_flat[4*k +: 4]) * int'(b_flat[8*k +: 4]);
        chk("basic_s0", 64'(s0), 64'd28);

        // Backpressure: in_valid ignored while full
        in_valid = 1'b1;
        in_data  = 4'h9;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_a_flat", a_flat, A0_EXP);
        end
        consume();
        in_valid = 1'b0;
        chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        chk("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
        chk("bp_release_a_flat", a_flat, A0_EXP);
        chk("bp_release_b_flat", {32'd0, b_flat}, {32'd0, B0_EXP});

        // Flush after 10 elements, with a simultaneous valid element
        send_range(1, 1'b0, 0, 9, 23);
        in_valid = 1'b1;
        in_data  = 4'h5;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_a_flat", a_flat, AFL_EXP);
        chk("flush_b_flat", {32'd0, b_flat}, {32'd0, B0_EXP});
        send_range(1, 1'b0, 0, 23, 23);
        chk("post_flush_out_valid", {63'd0, out_valid}, 64'd1);
        chk("post_flush_a_flat", a_flat, A1_EXP);
        chk("post_flush_b_flat", {32'd0, b_flat}, {32'd0, B1_EXP});
        consume();

        // Gapped input reproduces the reference frame
        send_range(0, 1'b1, 0, 23, 23);
        chk("gap_out_valid", {63'd0, out_valid}, 64'd1);
        chk("gap_a_flat", a_flat, A0_EXP);
        chk("gap_b_flat", {32'd0, b_flat}, {32'd0, B0_EXP});
        consume();

        // Asynchronous reset with idx=17
        send_range(1, 1'b0, 0, 16, 23);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_a_flat", a_flat, 64'd0);
        chk("arst_b_flat", {32'd0, b_flat}, 64'd0);
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_range(0, 1'b0, 0, 23, 23);
        chk("after_rst_out_valid", {63'd0, out_valid}, 64'd1);
        chk("after_rst_a_flat", a_flat, A0_EXP);
        chk("after_rst_b_flat", {32'd0, b_flat}, {32'd0, B0_EXP});
        consume();

        // Early in_last on element 12
        send_range(1, 1'b0, 0, 11, 11);
`ifdef MAT_LOAD_LAST_CHECK_EN
        chk("early_last_err", {63'd0, err}, 64'd1);
        chk("early_last_in_ready", {63'd0, in_ready}, 64'd1);
        chk("early_last_out_valid", {63'd0, out_valid}, 64'd0);
        send_range(1, 1'b0, 0, 23, 23);
        chk("recover_out_valid", {63'd0, out_valid}, 64'd1);
        chk("recover_a_flat", a_flat, A1_EXP);
        chk("recover_err_sticky", {63'd0, err}, 64'd1);
`else
        chk("early_last_err", {63'd0, err}, 64'd0);
        chk("early_last_out_valid", {63'd0, out_valid}, 64'd0);
        send_range(1, 1'b0, 12, 23, 23);
        chk("cont_out_valid", {63'd0, out_valid}, 64'd1);
        chk("cont_a_flat", a_flat, A1_EXP);
        chk("cont_b_flat", {32'd0, b_flat}, {32'd0, B1_EXP});
        chk("cont_err", {63'd0, err}, 64'd0);
`endif
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
